chess_control: RTL and testbench

Avalon-MM slave register/RAM block that gives the HPS or Nios master word-addressed storage for the chess engine's shared state: board, move lists and command/status words. Every one of the 2^ADDR_WIDTH slave addresses maps to one DATA_WIDTH-bit word of on-chip RAM; there are no unused or aliased addresses. The block sits between the Qsys interconnect and the engine datapath and is the only owner of this memory.

---
 rtl/chess_control.sv | 59 +++++
 tb/tb_chess_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/chess_control.sv
// chess_control: Avalon-MM slave exposing 2^ADDR_WIDTH words of on-chip RAM with fixed read latency 1.
// Optional macro CONTROL_BYTEENABLE_EN enables per-lane writes; otherwise every write updates the full word.
module chess_control #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     slave_address,
    input  logic                      slave_read,
    input  logic                      slave_write,
    input  logic [DATA_WIDTH-1:0]     slave_writedata,
    input  logic [DATA_WIDTH/8-1:0]   slave_byteenable,
    output logic [DATA_WIDTH-1:0]     slave_readdata
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic write_accept;
    logic read_accept;

    assign write_accept = slave_write && !reset;
    assign read_accept  = slave_read && !reset;

`ifdef CONTROL_BYTEENABLE_EN
    always_ff @(posedge clk) begin
        if (write_accept) begin
            for (int lane = 0; lane < NUM_LANES; lane++) begin
                if (slave_byteenable[lane]) begin
                    mem[slave_address][8*lane +: 8] <= slave_writedata[8*lane +: 8];
                end
            end
        end
    end
`else
    // Byte enables are ignored here; every accepted write replaces the whole word.
    logic [NUM_LANES-1:0] unused_byteenable;
    assign unused_byteenable = slave_byteenable;

    always_ff @(posedge clk) begin
        if (write_accept) begin
            mem[slave_address] <= slave_writedata;
        end
    end
`endif

    // Non-blocking RAM update means a same-address read sees the pre-write word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slave_readdata <= '0;
        end else if (read_accept) begin
            slave_readdata <= mem[slave_address];
        end
    end

endmodule

// File: tb/tb_chess_control.sv
// Self-checking bench for chess_control: directed test-plan sequences followed by randomized traffic
// checked against a word-array reference model (honours CONTROL_BYTEENABLE_EN like the design).
module tb_chess_control;

    localparam int DW = 32;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] slave_address;
    logic          slave_read;
    logic          slave_write;
    logic [DW-1:0] slave_writedata;
    logic [3:0]    slave_byteenable;
    logic [DW-1:0] slave_readdata;

    logic [DW-1:0] model [0:(1<<AW)-1];
    logic [DW-1:0] exp_rd;
    int checks = 0;
    int errors = 0;

    chess_control #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .slave_address    (slave_address),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_byteenable (slave_byteenable),
        .slave_readdata   (slave_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_word,
                                            input logic [DW-1:0] new_word,
                                            input logic [3:0] be);
`ifdef CONTROL_BYTEENABLE_EN
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mask = mask | (32'hFF << (8*i));
        end
        return (old_word & ~mask) | (new_word & mask);
`else
        return new_word;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of requests, then updates the model as of the rising edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd, input logic [3:0] be);
        slave_read       = rd;
        slave_write      = wr;
        slave_address    = addr;
        slave_writedata  = wd;
        slave_byteenable = be;
        @(posedge clk);
        if (!reset) begin
            if (rd) exp_rd = model[addr];
            if (wr) model[addr] = merge(model[addr], wd, be);
        end
        #1;
    endtask

    logic [AW-1:0] pool [0:9];

    initial begin
        for (int i = 0; i < (1<<AW); i++) model[i] = '0;
        exp_rd = '0;
        reset = 1'b1;
        slave_read = 1'b0;
        slave_write = 1'b0;
        slave_address = '0;
        slave_writedata = '0;
        slave_byteenable = '0;
        #1;
        checkOutput("reset_value", slave_readdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
            checkOutput("idle", slave_readdata, 32'h0);
        end

        applyStimulus(1'b0, 1'b1, 15'h0000, 32'hDEADBEEF, 4'hF);
        applyStimulus(1'b0, 1'b1, 15'h7FFF, 32'h12345678, 4'hF);
        checkOutput("no_read_hold", slave_readdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        checkOutput("b2b_rd0", slave_readdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 15'h7FFF, 32'h0, 4'h0);
        checkOutput("b2b_rd7fff", slave_readdata, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        checkOutput("b2b_rd0_again", slave_readdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 15'h0001, 32'h0, 4'h0);
        checkOutput("unwritten", slave_readdata, 32'h0);
        applyStimulus(1'b0, 1'b0, 15'h0001, 32'h0, 4'h0);
        checkOutput("hold_after_read", slave_readdata, 32'h0);

        applyStimulus(1'b0, 1'b1, 15'h0010, 32'hFFFFFFFF, 4'hF);
        applyStimulus(1'b0, 1'b1, 15'h0010, 32'h00000000, 4'b0101);
        applyStimulus(1'b1, 1'b0, 15'h0010, 32'h0, 4'h0);
`ifdef CONTROL_BYTEENABLE_EN
        checkOutput("byte_lanes", slave_readdata, 32'hFF00FF00);
`else
        checkOutput("byte_lanes", slave_readdata, 32'h00000000);
`endif
        applyStimulus(1'b0, 1'b1, 15'h0011, 32'hCAFEF00D, 4'h0);
        applyStimulus(1'b1, 1'b0, 15'h0011, 32'h0, 4'h0);
`ifdef CONTROL_BYTEENABLE_EN
        checkOutput("be_zero", slave_readdata, 32'h00000000);
`else
        checkOutput("be_zero", slave_readdata, 32'hCAFEF00D);
`endif

        applyStimulus(1'b0, 1'b1, 15'h0020, 32'h11111111, 4'hF);
        applyStimulus(1'b1, 1'b1, 15'h0020, 32'h22222222, 4'hF);
        checkOutput("rw_same_old", slave_readdata, 32'h11111111);
        applyStimulus(1'b1, 1'b0, 15'h0020, 32'h0, 4'h0);
        checkOutput("rw_same_new", slave_readdata, 32'h22222222);
        applyStimulus(1'b1, 1'b1, 15'h0000, 32'h33333333, 4'hF);
        checkOutput("rw_diff_rd", slave_readdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        checkOutput("rw_diff_wr", slave_readdata, 32'h33333333);
        applyStimulus(1'b0, 1'b1, 15'h0000, 32'hDEADBEEF, 4'hF);

        applyStimulus(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        checkOutput("pre_reset_rd", slave_readdata, 32'hDEADBEEF);
        reset = 1'b1;
        exp_rd = '0;
        #1;
        checkOutput("async_reset", slave_readdata, 32'h0);
        applyStimulus(1'b1, 1'b1, 15'h0000, 32'hAAAAAAAA, 4'hF);
        checkOutput("reset_rd_discard", slave_readdata, 32'h0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        checkOutput("ram_retained", slave_readdata, 32'hDEADBEEF);

        pool[0] = 15'h0000; pool[1] = 15'h0001; pool[2] = 15'h0010; pool[3] = 15'h0020;
        pool[4] = 15'h7FFF;
        for (int i = 5; i < 10; i++) pool[i] = AW'($urandom_range(0, (1<<AW)-1));
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          pool[$urandom_range(0, 9)], DW'($urandom), 4'($urandom_range(0, 15)));
            checkOutput("random", slave_readdata, exp_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
